mem_fill_responder: RTL and testbench
=====================================

MEM_FILL_RESPONDER -- requirements
Module: mem_fill_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: byte address width; words are 16 bits, addr[0] ignored.
REQ-002 Parameter DEPTH_LOG2, default 10: storage holds 2^DEPTH_LOG2 words, indexed by addr[DEPTH_LOG2:1].
REQ-003 Parameter LATENCY, default 4: read issue to data return, in cycles; legal range 1..8.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  request strobe; one request accepted per cycle, no back-pressure.
REQ-007 wr  input  1  with enable: 1 = write, 0 = read.
REQ-008 addr  input  ADDR_WIDTH  request byte address.
REQ-009 data_in  input  16  write data.
REQ-010 memory_data  output  16  returned read data.
REQ-011 memory_data_valid  output  1  memory_data and return_address valid this cycle.
REQ-012 return_address  output  ADDR_WIDTH  address of the read currently returning (addr[0] forced 0).
REQ-013 outstanding  output  4  count of reads issued but not yet returned.

Function
REQ-014 Read issue: enable=1, wr=0 at edge N; array word at addr sampled at edge N (pre-write value of any write in the same edge is impossible, single port).
REQ-015 Read return: memory_data_valid=1 for exactly one cycle, starting edge N+LATENCY, with the sampled word and its address.
REQ-016 Pipelined: a read may issue every cycle; N back-to-back reads yield N consecutive valid cycles, in issue order.
REQ-017 Return path is a LATENCY-stage shift register of {valid, address, data}; stage 0 loaded at issue, one stage advanced per edge.
REQ-018 Write: enable=1, wr=1 updates array word at addr at that edge; no valid pulse, no effect on outstanding.
REQ-019 Write-after-read hazard: a write to an address with a read in flight does not change that read's returned data (old value returned).
REQ-020 Read-after-write: a read issued the edge after a write returns the new value.
REQ-021 enable=0: no array access; pipeline still advances.
REQ-022 When memory_data_valid=0, memory_data and return_address are 0.
REQ-023 outstanding: +1 on read issue, -1 on return; both in the same edge leave it unchanged; max value LATENCY, never wraps.
REQ-024 Address bits above DEPTH_LOG2 are ignored (aliasing); no error.

Reset
REQ-025 rst=0 asynchronously clears all pipeline valid bits, addresses and data; memory_data_valid=0, memory_data=0, return_address=0, outstanding=0 immediately, without waiting for a clock edge.
REQ-026 Reads in flight at reset are discarded; no valid pulse for them after release.
REQ-027 Array contents are not affected by reset.
REQ-028 Requests presented while rst=0 are ignored; first accepted request is at the first rising edge with rst=1.

Verification
REQ-029 Write 0xBEEF to 0x0010, read 0x0010 next cycle -> valid pulse exactly 4 cycles after read issue, memory_data=0xBEEF, return_address=0x0010.
REQ-030 Block fill: 8 back-to-back reads 0x0040..0x004E step 2, after writing 0x1000+i to each -> 8 consecutive valid cycles, data 0x1000..0x1007 in order; outstanding peaks at 4.
REQ-031 Read 0x0020 (holding 0x1111), next cycle write 0x2222 to 0x0020 -> returned data 0x1111; later read returns 0x2222.
REQ-032 Issue 3 reads, assert rst=0 mid-cycle two cycles later -> valid, outputs and outstanding go 0 immediately; no valid pulse after release; previously written data still readable.
REQ-033 Alternating read/idle/write traffic for 200 random cycles vs. a reference model -> every return matches model data, address and cycle; outstanding always equals model count.
REQ-034 LATENCY=1 build: read at edge N -> valid at edge N+1; continuous reads give continuous valid with outstanding=1.

Source files
------------

// File: rtl/mem_fill_responder.sv
// Single-port word memory with a fixed-latency pipelined read return path.
// Reads sample the array at issue and ride a LATENCY-deep {valid, address, data} shift register.
module mem_fill_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [15:0]           data_in,
    output logic [15:0]           memory_data,
    output logic                  memory_data_valid,
    output logic [ADDR_WIDTH-1:0] return_address,
    output logic [3:0]            outstanding
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(1);

    logic [15:0]           mem_array [DEPTH];

    logic [ADDR_WIDTH-1:0] addr_aligned;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  read_issue;
    logic                  mem_we;
    logic [15:0]           rd_word;

    logic [LATENCY-1:0]    valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q [LATENCY];
    logic [ADDR_WIDTH-1:0] addr_d [LATENCY];
    logic [15:0]           data_q [LATENCY];
    logic [15:0]           data_d [LATENCY];
    logic [3:0]            outstanding_q, outstanding_d;

    // Writes are blocked while reset is held so nothing is accepted before release.
    always_comb begin
        addr_aligned = addr & ALIGN_MASK;
        word_idx     = addr_aligned[DEPTH_LOG2:1];
        read_issue   = enable & ~wr;
        mem_we       = enable & wr & rst;
        rd_word      = mem_array[word_idx];
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_array[word_idx] <= data_in;
        end
    end

    // Idle stages carry zeros, so the outputs read 0 whenever no return is present.
    always_comb begin
        valid_d    = '0;
        valid_d[0] = read_issue;
        addr_d[0]  = read_issue ? addr_aligned : '0;
        data_d[0]  = read_issue ? rd_word : '0;
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            addr_d[i]  = addr_q[i-1];
            data_d[i]  = data_q[i-1];
        end
        outstanding_d = outstanding_q + 4'(read_issue) - 4'(valid_q[LATENCY-1]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            outstanding_q <= '0;
        end else begin
            valid_q       <= valid_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign memory_data_valid = valid_q[LATENCY-1];
    assign memory_data       = data_q[LATENCY-1];
    assign return_address    = addr_q[LATENCY-1];
    assign outstanding       = outstanding_q;

endmodule

// File: tb/tb_mem_fill_responder.sv
// Self-checking bench: LATENCY=4 and LATENCY=1 builds driven in lockstep and compared with a
// history-based model; a read issued at edge N is expected on the outputs sampled at edge N+LATENCY.
module tb_mem_fill_responder;

    localparam int LAT4 = 4;
    localparam int HIST = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;

    logic [15:0] mem_data4, raddr4, mem_data1, raddr1;
    logic        valid4, valid1;
    logic [3:0]  outst4, outst1;

    int n_checks = 0;
    int n_fail   = 0;
    int ec       = 0;

    logic        hist_v [HIST];
    logic [15:0] hist_a [HIST];
    logic [15:0] hist_d [HIST];
    logic [15:0] ref_mem [1024];

    typedef struct packed {
        logic        v;
        logic [15:0] a;
        logic [15:0] d;
        logic [3:0]  o;
    } exp_t;

    mem_fill_responder #(.ADDR_WIDTH(16), .DEPTH_LOG2(10), .LATENCY(LAT4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
        .memory_data(mem_data4), .memory_data_valid(valid4),
        .return_address(raddr4), .outstanding(outst4)
    );

    mem_fill_responder #(.ADDR_WIDTH(16), .DEPTH_LOG2(10), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
        .memory_data(mem_data1), .memory_data_valid(valid1),
        .return_address(raddr1), .outstanding(outst1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs after edge ec: the read issued LATENCY-1 edges ago is on the outputs,
    // and every read issued within the last LATENCY edges is still outstanding.
    function automatic exp_t expect_at(input int lat);
        exp_t e;
        int   idx;
        e   = '0;
        idx = ec - lat + 1;
        if (idx >= 0 && hist_v[idx]) begin
            e.v = 1'b1;
            e.a = hist_a[idx];
            e.d = hist_d[idx];
        end
        for (int k = 0; k < lat; k++) begin
            if (ec - k >= 0 && hist_v[ec-k]) e.o = e.o + 4'd1;
        end
        return e;
    endfunction

    task automatic check_all(input string tag);
        exp_t e4, e1;
        e4 = expect_at(LAT4);
        e1 = expect_at(1);
        check_output({tag, "/valid4"}, 32'(valid4),    32'(e4.v));
        check_output({tag, "/data4"},  32'(mem_data4), 32'(e4.d));
        check_output({tag, "/addr4"},  32'(raddr4),    32'(e4.a));
        check_output({tag, "/outst4"}, 32'(outst4),    32'(e4.o));
        check_output({tag, "/valid1"}, 32'(valid1),    32'(e1.v));
        check_output({tag, "/data1"},  32'(mem_data1), 32'(e1.d));
        check_output({tag, "/addr1"},  32'(raddr1),    32'(e1.a));
        check_output({tag, "/outst1"}, 32'(outst1),    32'(e1.o));
    endtask

    // Drive one request at the falling edge, let the model see the rising edge, check at the next fall.
    task automatic apply_stimulus(input logic en, input logic w, input logic [15:0] a,
                                  input logic [15:0] d, input string tag);
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        ec++;
        hist_v[ec] = 1'b0;
        if (rst) begin
            if (en && !w) begin
                hist_v[ec] = 1'b1;
                hist_a[ec] = {a[15:1], 1'b0};
                hist_d[ec] = ref_mem[a[10:1]];
            end
            if (en && w) ref_mem[a[10:1]] = d;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic wait_return(input string tag, input logic [15:0] exp_d, input logic [15:0] exp_a,
                               output int waited);
        waited = 0;
        while (!valid4 && waited < 10) begin
            apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0, tag);
            waited++;
        end
        check_output({tag, "/seen"}, 32'(valid4),    32'd1);
        check_output({tag, "/data"}, 32'(mem_data4), 32'(exp_d));
        check_output({tag, "/addr"}, 32'(raddr4),    32'(exp_a));
    endtask

    initial begin
        int          waited;
        int          peak;
        int          nseen;
        logic [31:0] r;
        logic [9:0]  widx;
        logic [15:0] a;

        for (int i = 0; i < HIST; i++) hist_v[i] = 1'b0;
        rst     = 1'b0;
        enable  = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        data_in = '0;
        repeat (3) @(negedge clk);
        check_all("reset_state");
        rst = 1'b1;

        apply_stimulus(1'b1, 1'b1, 16'h0010, 16'hBEEF, "beef_wr");
        apply_stimulus(1'b1, 1'b0, 16'h0010, 16'h0000, "beef_rd");
        wait_return("beef", 16'hBEEF, 16'h0010, waited);
        check_output("beef/latency", 32'(waited), 32'(LAT4 - 1));
        apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0, "beef_after");
        check_output("beef/single_pulse", 32'(valid4), 32'd0);

        for (int i = 0; i < 8; i++)
            apply_stimulus(1'b1, 1'b1, 16'(16'h0040 + 2 * i), 16'(16'h1000 + i), "fill_wr");
        peak  = 0;
        nseen = 0;
        for (int k = 0; k < 12; k++) begin
            apply_stimulus(k < 8, 1'b0, 16'(16'h0040 + 2 * k), 16'h0, "fill_rd");
            if (k < 8) begin
                check_output("l1/valid",  32'(valid1),    32'd1);
                check_output("l1/data",   32'(mem_data1), 32'(16'h1000 + k));
                check_output("l1/outst",  32'(outst1),    32'd1);
            end
            if (int'(outst4) > peak) peak = int'(outst4);
            if (valid4) begin
                check_output("fill/order", 32'(mem_data4), 32'(16'h1000 + nseen));
                nseen++;
            end
        end
        check_output("fill/count", 32'(nseen), 32'd8);
        check_output("fill/peak",  32'(peak),  32'(LAT4));

        apply_stimulus(1'b1, 1'b1, 16'h0020, 16'h1111, "war_wr1");
        apply_stimulus(1'b1, 1'b0, 16'h0020, 16'h0000, "war_rd1");
        apply_stimulus(1'b1, 1'b1, 16'h0020, 16'h2222, "war_wr2");
        wait_return("war_old", 16'h1111, 16'h0020, waited);
        apply_stimulus(1'b1, 1'b0, 16'h0021, 16'h0000, "war_rd2");
        wait_return("war_new", 16'h2222, 16'h0020, waited);
        repeat (4) apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0, "idle");

        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b1, 1'b0, 16'(16'h0040 + 2 * i), 16'h0, "rst_rd");
        check_output("rst/outst_before", 32'(outst4), 32'd3);
        rst = 1'b0;
        #1;
        check_output("rst/valid4", 32'(valid4),    32'd0);
        check_output("rst/outst4", 32'(outst4),    32'd0);
        check_output("rst/valid1", 32'(valid1),    32'd0);
        check_output("rst/data1",  32'(mem_data1), 32'd0);
        check_output("rst/addr1",  32'(raddr1),    32'd0);
        check_output("rst/outst1", 32'(outst1),    32'd0);
        for (int i = 0; i <= ec; i++) hist_v[i] = 1'b0;
        apply_stimulus(1'b1, 1'b1, 16'h0042, 16'hDEAD, "rst_held_wr");
        apply_stimulus(1'b1, 1'b0, 16'h0040, 16'h0000, "rst_held_rd");
        rst = 1'b1;
        repeat (6) apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0, "post_rst");
        apply_stimulus(1'b1, 1'b0, 16'h0042, 16'h0000, "post_rst_rd");
        wait_return("post_rst_42", 16'h1001, 16'h0042, waited);
        apply_stimulus(1'b1, 1'b0, 16'h0040, 16'h0000, "post_rst_rd");
        wait_return("post_rst_40", 16'h1000, 16'h0040, waited);

        for (int i = 0; i < 16; i++)
            apply_stimulus(1'b1, 1'b1, 16'(16'h0200 + 2 * i), 16'($urandom), "rand_init");
        for (int c = 0; c < 200; c++) begin
            r    = $urandom;
            widx = 10'h100 | 10'($urandom_range(0, 15));
            a    = {r[4:0], widx, r[5]};
            case ($urandom_range(0, 2))
                0:       apply_stimulus(1'b1, 1'b0, a, 16'h0, "rand_rd");
                1:       apply_stimulus(1'b0, 1'b0, a, 16'h0, "rand_idle");
                default: apply_stimulus(1'b1, 1'b1, a, 16'($urandom), "rand_wr");
            endcase
        end
        repeat (LAT4 + 1) apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0, "drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
